data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter LINE_NUM, default 16, meaning number of direct-mapped lines (power of two).
REQ-002 SHALL have parameter BLOCK_WORDS, default 4, meaning 32-bit words per line (16 B).
REQ-003 SHALL have the port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have the port reset, input, 1 bit, meaning reset; it is asynchronous and active-low (0 = reset).
REQ-005 SHALL have CPU-side ports:
- is_input_valid, in, 1: MEM-stage request present.
- addr, in, 32: byte address.
- mem_rw, in, 1: 0 = load, 1 = store.
- din, in, 32: store data.
- is_ready, out, 1: cache can accept a request.
- is_output_valid, out, 1: request complete; dout valid for loads.
- dout, out, 32: load data.
- is_hit, out, 1: the completing request hit on first lookup.
REQ-006 SHALL have memory-side ports:
- mem_req_valid, out, 1: request to backing memory.
- mem_req_ready, in, 1: memory accepts the request.
- mem_req_write, out, 1: 1 = writeback, 0 = fill.
- mem_req_addr, out, 32: block-aligned address.
- mem_req_data, out, 32*BLOCK_WORDS: writeback line.
- mem_resp_valid, in, 1: fill data present.
- mem_resp_data, in, 32*BLOCK_WORDS: fill line.
REQ-007 SHALL have statistics ports hit_count, out, 32 and miss_count, out, 32.

Function
REQ-008 SHALL split addr as tag = [31:8], index = [7:4], word = [3:2]; addr[1:0] are ignored.
REQ-009 SHALL accept a request only when is_input_valid && is_ready, and SHALL latch addr, mem_rw and din at acceptance.
REQ-010 SHALL drive is_ready = 1 only in IDLE.
REQ-011 SHALL implement the FSM IDLE -> LOOKUP, with LOOKUP continuing as follows:
- hit -> IDLE.
- miss on a clean or invalid line -> FILL_REQ.
- miss on a dirty line -> WRITEBACK.
- WRITEBACK -> FILL_REQ.
- FILL_REQ -> FILL_WAIT.
- FILL_WAIT -> LOOKUP.
REQ-012 SHALL complete a hit in LOOKUP, one cycle after acceptance: is_output_valid = 1 for exactly that cycle, dout = selected word for a load; a store writes din and sets dirty.
REQ-013 In WRITEBACK, SHALL hold mem_req_valid = 1, mem_req_write = 1, mem_req_addr = {old tag, index, 4'b0} and mem_req_data = line until mem_req_ready; it SHALL leave on the cycle mem_req_ready = 1.
REQ-014 In FILL_REQ, SHALL hold mem_req_valid = 1, mem_req_write = 0, mem_req_addr = {addr[31:4], 4'b0} until mem_req_ready.
REQ-015 In FILL_WAIT, on mem_resp_valid SHALL write mem_resp_data, set valid, clear dirty, store the tag and return to LOOKUP, which then hits.
REQ-016 SHALL drive is_hit = 1 with is_output_valid only if no miss occurred for that request; a post-fill completion has is_hit = 0.
REQ-017 SHALL increment hit_count once per first-lookup hit and miss_count once per first-lookup miss; both wrap modulo 2^32.
REQ-018 SHALL ignore mem_resp_valid outside FILL_WAIT and mem_req_ready outside WRITEBACK/FILL_REQ.
REQ-019 SHALL ignore is_input_valid while is_ready = 0; the requester holds its request.
REQ-020 SHALL place word w of a line at bits [32w+31:32w] of every line bus.
REQ-021 Outside completion, dout SHALL be 0 and is_output_valid SHALL be 0.

Reset
REQ-022 On reset = 0, SHALL immediately and asynchronously:
- enter IDLE and clear all valid and dirty bits;
- zero hit_count, miss_count, dout, is_output_valid, is_hit and mem_req_valid;
- drive is_ready = 0 while reset is asserted.
REQ-023 Reset mid-miss SHALL abandon the transaction; a later mem_resp_valid SHALL be ignored.
REQ-024 Data-array contents need no reset.

Structure
REQ-025 The shared package SHALL hold the FSM state encoding, the TAG/INDEX/OFFSET width constants and the default line geometry.
REQ-026 Tag, valid, dirty and data storage SHALL be a single sub-module, cache_line_array, with a combinational read port and a synchronous write port.

Verification
REQ-027 Load 0x100 after reset -> miss, fill request to 0x100, completion with is_hit = 0, miss_count = 1.
REQ-028 Store 0xDEADBEEF to 0x104, then load 0x104 -> second completes 1 cycle after acceptance: dout = 0xDEADBEEF, is_hit = 1.
REQ-029 Dirty line at 0x104, then load 0x904 (same index 0) -> writeback with addr 0x100 and data word1 = 0xDEADBEEF, then fill from 0x900.
REQ-030 Hold mem_req_ready = 0 for 5 cycles in FILL_REQ -> mem_req_valid and mem_req_addr stay stable, and no completion occurs.
REQ-031 Assert reset in FILL_WAIT, then pulse mem_resp_valid -> cache stays IDLE, line 0 invalid, and the next load 0x100 misses.
REQ-032 Stray mem_resp_valid in IDLE -> no state change and no counter change.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped data cache: address geometry,
// default line organisation and the controller state encoding.
package data_cache_pkg;

    localparam int ADDR_WIDTH   = 32;
    localparam int INDEX_WIDTH  = 4;
    localparam int OFFSET_WIDTH = 4;
    localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

    localparam int DEFAULT_LINE_NUM    = 1 << INDEX_WIDTH;
    localparam int DEFAULT_BLOCK_WORDS = 1 << (OFFSET_WIDTH - 2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        FILL_REQ  = 3'd3,
        FILL_WAIT = 3'd4
    } cache_state_t;

endpackage

// File: rtl/data_cache_cache_line_array.sv
// Tag, valid, dirty and data storage for the direct-mapped cache.
// One combinational read port selected by i_index and a synchronous write
// port used either for a whole-line fill or for a single-word store.
module cache_line_array
    import data_cache_pkg::*;
#(
    parameter int LINE_NUM    = DEFAULT_LINE_NUM,
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int TAG_W       = TAG_WIDTH,
    parameter int IDX_W       = $clog2(LINE_NUM),
    parameter int WORD_W      = $clog2(BLOCK_WORDS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [IDX_W-1:0]          i_index,
    output logic                      o_valid,
    output logic                      o_dirty,
    output logic [TAG_W-1:0]          o_tag,
    output logic [32*BLOCK_WORDS-1:0] o_data,
    input  logic                      i_fillEn,
    input  logic [TAG_W-1:0]          i_fillTag,
    input  logic [32*BLOCK_WORDS-1:0] i_fillData,
    input  logic                      i_storeEn,
    input  logic [WORD_W-1:0]         i_storeWord,
    input  logic [31:0]               i_storeData
);

    logic [LINE_NUM-1:0]      r_valid;
    logic [LINE_NUM-1:0]      r_dirty;
    logic [TAG_W-1:0]         r_tag  [LINE_NUM];
    logic [32*BLOCK_WORDS-1:0] r_data [LINE_NUM];

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_data  = r_data[i_index];

    // Line status bits: reset invalidates every line; a fill makes the line clean, a store dirties it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fillEn) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_storeEn) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    // Tag and data payload; contents are meaningless until the valid bit is set, so no reset
    always_ff @(posedge clk) begin
        if (i_fillEn) begin
            r_tag[i_index]  <= i_fillTag;
            r_data[i_index] <= i_fillData;
        end else if (i_storeEn) begin
            r_data[i_index][{i_storeWord, 5'b0} +: 32] <= i_storeData;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
// A request is latched on acceptance, looked up for one cycle, and on a miss
// the victim is written back (if dirty) before the line is refilled and the
// lookup repeated. Completion is decoded from the LOOKUP state so that a hit
// completes in the cycle directly after acceptance.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int LINE_NUM    = DEFAULT_LINE_NUM,
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      is_input_valid,
    input  logic [31:0]               addr,
    input  logic                      mem_rw,
    input  logic [31:0]               din,
    output logic                      is_ready,
    output logic                      is_output_valid,
    output logic [31:0]               dout,
    output logic                      is_hit,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_write,
    output logic [31:0]               mem_req_addr,
    output logic [32*BLOCK_WORDS-1:0] mem_req_data,
    input  logic                      mem_resp_valid,
    input  logic [32*BLOCK_WORDS-1:0] mem_resp_data,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
);

    localparam int IDX_W  = $clog2(LINE_NUM);
    localparam int WORD_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
    localparam logic [31:0] OFF_MASK = 32'((64'd1 << OFF_W) - 64'd1);

    cache_state_t r_state;
    logic [31:0]  r_addr;
    logic [31:0]  r_din;
    logic         r_rw;
    logic         r_ready;
    logic         r_missed;
    logic [31:0]  r_hitCount;
    logic [31:0]  r_missCount;

    logic [IDX_W-1:0]          w_index;
    logic [TAG_W-1:0]          w_tag;
    logic [WORD_W-1:0]         w_word;
    logic                      w_lineValid;
    logic                      w_lineDirty;
    logic [TAG_W-1:0]          w_lineTag;
    logic [32*BLOCK_WORDS-1:0] w_lineData;
    logic [31:0]               w_selWord;
    logic                      w_hit;
    logic                      w_complete;
    logic                      w_fillEn;
    logic                      w_storeEn;

    assign w_index = r_addr[OFF_W +: IDX_W];
    assign w_tag   = r_addr[31 -: TAG_W];
    assign w_word  = r_addr[2 +: WORD_W];

    cache_line_array #(
        .LINE_NUM    (LINE_NUM),
        .BLOCK_WORDS (BLOCK_WORDS),
        .TAG_W       (TAG_W),
        .IDX_W       (IDX_W),
        .WORD_W      (WORD_W)
    ) u_lines (
        .clk         (clk),
        .reset       (reset),
        .i_index     (w_index),
        .o_valid     (w_lineValid),
        .o_dirty     (w_lineDirty),
        .o_tag       (w_lineTag),
        .o_data      (w_lineData),
        .i_fillEn    (w_fillEn),
        .i_fillTag   (w_tag),
        .i_fillData  (mem_resp_data),
        .i_storeEn   (w_storeEn),
        .i_storeWord (w_word),
        .i_storeData (r_din)
    );

    assign w_selWord  = w_lineData[{w_word, 5'b0} +: 32];
    assign w_hit      = w_lineValid && (w_lineTag == w_tag);
    assign w_complete = (r_state == LOOKUP) && w_hit;
    assign w_fillEn   = (r_state == FILL_WAIT) && mem_resp_valid;
    assign w_storeEn  = w_complete && r_rw;

    assign is_ready        = r_ready;
    assign is_output_valid = w_complete;
    assign is_hit          = w_complete && !r_missed;
    assign dout            = (w_complete && !r_rw) ? w_selWord : 32'd0;
    assign hit_count       = r_hitCount;
    assign miss_count      = r_missCount;

    // Memory request channel: victim writeback or block-aligned fill, held until accepted
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = 32'd0;
        mem_req_data  = '0;
        case (r_state)
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = {w_lineTag, w_index, {OFF_W{1'b0}}};
                mem_req_data  = w_lineData;
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = r_addr & ~OFF_MASK;
            end
            default: ;
        endcase
    end

    // Controller: request latching, miss handling sequence and first-lookup statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_addr      <= 32'd0;
            r_din       <= 32'd0;
            r_rw        <= 1'b0;
            r_ready     <= 1'b0;
            r_missed    <= 1'b0;
            r_hitCount  <= 32'd0;
            r_missCount <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_ready && is_input_valid) begin
                        r_addr   <= addr;
                        r_din    <= din;
                        r_rw     <= mem_rw;
                        r_missed <= 1'b0;
                        r_ready  <= 1'b0;
                        r_state  <= LOOKUP;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        if (!r_missed) begin
                            r_hitCount <= r_hitCount + 32'd1;
                        end
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        if (!r_missed) begin
                            r_missCount <= r_missCount + 32'd1;
                        end
                        r_missed <= 1'b1;
                        r_state  <= (w_lineValid && w_lineDirty) ? WRITEBACK : FILL_REQ;
                    end
                end
                WRITEBACK: begin
                    if (mem_req_ready) begin
                        r_state <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (mem_resp_valid) begin
                        r_state <= LOOKUP;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache. The reference is a flat word-addressed
// memory image plus a per-index record of which block is resident and dirty;
// a behavioural backing memory answers the cache's fill and writeback traffic.
module tb_data_cache;
    import data_cache_pkg::*;

    localparam int LINES = DEFAULT_LINE_NUM;
    localparam int WORDS = DEFAULT_BLOCK_WORDS;

    logic                clk;
    logic                reset;
    logic                is_input_valid;
    logic [31:0]         addr;
    logic                mem_rw;
    logic [31:0]         din;
    logic                is_ready;
    logic                is_output_valid;
    logic [31:0]         dout;
    logic                is_hit;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_req_write;
    logic [31:0]         mem_req_addr;
    logic [32*WORDS-1:0] mem_req_data;
    logic                mem_resp_valid;
    logic [32*WORDS-1:0] mem_resp_data;
    logic [31:0]         hit_count;
    logic [31:0]         miss_count;

    int checkCount = 0;
    int errorCount = 0;

    // Reference state: architectural memory image and resident-block bookkeeping
    logic [31:0]          gold    [bit [31:0]];
    logic [31:0]          backMem [bit [31:0]];
    bit                   mValid  [LINES];
    bit                   mDirty  [LINES];
    logic [TAG_WIDTH-1:0] mTag    [LINES];
    int                   expHits;
    int                   expMisses;

    data_cache dut (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (is_input_valid),
        .addr            (addr),
        .mem_rw          (mem_rw),
        .din             (din),
        .is_ready        (is_ready),
        .is_output_valid (is_output_valid),
        .dout            (dout),
        .is_hit          (is_hit),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_write   (mem_req_write),
        .mem_req_addr    (mem_req_addr),
        .mem_req_data    (mem_req_data),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something escapes the per-request cycle budgets
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] initWord(input logic [31:0] wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] readGold(input logic [31:0] wa);
        return gold.exists(wa) ? gold[wa] : initWord(wa);
    endfunction

    function automatic logic [31:0] readBack(input logic [31:0] wa);
        return backMem.exists(wa) ? backMem[wa] : initWord(wa);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitReady();
        int cycles = 0;
        while (!is_ready && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("readyWait", 64'(is_ready), 64'd1);
    endtask

    // One CPU request with memory-side servicing; stall < 0 picks random ready delays
    task automatic applyStimulus(input logic rw, input logic [31:0] a, input logic [31:0] d, input int stall);
        int                   idx;
        logic [TAG_WIDTH-1:0] tg;
        logic [31:0]          wa;
        bit                   expHit;
        bit                   expWb;
        logic [31:0]          wbAddr;
        logic [31:0]          fillAddr;
        bit                   sawWb;
        bit                   sawFill;
        bit                   reqActive;
        bit                   reqWrite;
        logic [31:0]          reqAddr;
        bit                   waitResp;
        int                   respDelay;
        int                   stallLeft;
        int                   cycles;

        idx      = int'(a[OFFSET_WIDTH +: INDEX_WIDTH]);
        tg       = a[31 -: TAG_WIDTH];
        wa       = a & ~32'd3;
        expHit   = mValid[idx] && (mTag[idx] == tg);
        expWb    = !expHit && mValid[idx] && mDirty[idx];
        wbAddr   = {mTag[idx], a[OFFSET_WIDTH +: INDEX_WIDTH], {OFFSET_WIDTH{1'b0}}};
        fillAddr = a & ~32'hF;
        sawWb = 0; sawFill = 0; reqActive = 0; reqWrite = 0; reqAddr = 0;
        waitResp = 0; respDelay = 0; stallLeft = 0;

        waitReady();
        is_input_valid = 1'b1;
        addr           = a;
        mem_rw         = rw;
        din            = d;
        @(negedge clk);
        is_input_valid = 1'b0;
        addr           = $urandom;
        din            = $urandom;
        mem_rw         = $urandom_range(0, 1);
        cycles         = 1;

        while (!is_output_valid && cycles < 200) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (!reqActive && !waitResp && mem_req_valid) begin
                reqActive = 1;
                reqWrite  = expWb && !sawWb;
                reqAddr   = reqWrite ? wbAddr : fillAddr;
                stallLeft = (stall >= 0) ? stall : int'($urandom_range(0, 2));
                if (reqWrite) sawWb = 1;
                else          sawFill = 1;
            end
            if (reqActive) begin
                checkOutput("reqValid", 64'(mem_req_valid), 64'd1);
                checkOutput("reqWrite", 64'(mem_req_write), 64'(reqWrite));
                checkOutput("reqAddr", 64'(mem_req_addr), 64'(reqAddr));
                if (reqWrite) begin
                    for (int w = 0; w < WORDS; w++) begin
                        checkOutput("wbData", 64'(mem_req_data[32*w +: 32]), 64'(readGold(reqAddr + 32'(4*w))));
                    end
                end
                if (stallLeft > 0) begin
                    stallLeft--;
                end else begin
                    mem_req_ready = 1'b1;
                    reqActive     = 0;
                    if (reqWrite) begin
                        for (int w = 0; w < WORDS; w++) begin
                            backMem[reqAddr + 32'(4*w)] = mem_req_data[32*w +: 32];
                        end
                    end else begin
                        waitResp  = 1;
                        respDelay = $urandom_range(1, 3);
                    end
                end
            end else if (waitResp) begin
                mem_req_ready = $urandom_range(0, 1);
                respDelay--;
                if (respDelay <= 0) begin
                    mem_resp_valid = 1'b1;
                    for (int w = 0; w < WORDS; w++) begin
                        mem_resp_data[32*w +: 32] = readBack(fillAddr + 32'(4*w));
                    end
                    waitResp = 0;
                end
            end
            @(negedge clk);
            cycles++;
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;

        checkOutput("complete", 64'(is_output_valid), 64'd1);
        checkOutput("isHit", 64'(is_hit), 64'(expHit));
        checkOutput("dout", 64'(dout), rw ? 64'd0 : 64'(readGold(wa)));
        checkOutput("sawWb", 64'(sawWb), 64'(expWb));
        checkOutput("sawFill", 64'(sawFill), 64'(!expHit));
        checkOutput("reqLeft", 64'(reqActive), 64'd0);
        if (expHit) checkOutput("hitLatency", 64'(cycles), 64'd1);

        if (rw) gold[wa] = d;
        if (expHit) begin
            expHits++;
            mDirty[idx] = mDirty[idx] | rw;
        end else begin
            expMisses++;
            mDirty[idx] = rw;
        end
        mValid[idx] = 1;
        mTag[idx]   = tg;

        @(negedge clk);
        checkOutput("validAfter", 64'(is_output_valid), 64'd0);
        checkOutput("doutAfter", 64'(dout), 64'd0);
        checkOutput("hitCount", 64'(hit_count), 64'(expHits));
        checkOutput("missCount", 64'(miss_count), 64'(expMisses));
    endtask

    // A fill response arriving while idle must change nothing
    task automatic strayResp();
        waitReady();
        mem_resp_valid = 1'b1;
        mem_resp_data  = {WORDS{32'hBAD0_BAD0}};
        mem_req_ready  = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        checkOutput("strayValid", 64'(is_output_valid), 64'd0);
        checkOutput("strayReq", 64'(mem_req_valid), 64'd0);
        checkOutput("strayReady", 64'(is_ready), 64'd1);
        checkOutput("strayHits", 64'(hit_count), 64'(expHits));
        checkOutput("strayMiss", 64'(miss_count), 64'(expMisses));
    endtask

    // Reset while waiting for fill data, then deliver the now-orphaned response
    task automatic resetDuringFill();
        int cycles = 0;
        bit gotFill = 0;
        waitReady();
        is_input_valid = 1'b1;
        addr           = 32'h00AB_CD00;
        mem_rw         = 1'b0;
        @(negedge clk);
        is_input_valid = 1'b0;
        while (!gotFill && cycles < 50) begin
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                mem_req_ready = 1'b1;
                if (mem_req_write) begin
                    for (int w = 0; w < WORDS; w++) begin
                        backMem[mem_req_addr + 32'(4*w)] = mem_req_data[32*w +: 32];
                    end
                end else begin
                    gotFill = 1;
                end
            end
            @(negedge clk);
            cycles++;
        end
        mem_req_ready = 1'b0;
        checkOutput("rstReachFill", 64'(gotFill), 64'd1);

        #2 reset = 1'b0;
        #1;
        checkOutput("rstReady", 64'(is_ready), 64'd0);
        checkOutput("rstReqValid", 64'(mem_req_valid), 64'd0);
        checkOutput("rstOutValid", 64'(is_output_valid), 64'd0);
        checkOutput("rstHitCnt", 64'(hit_count), 64'd0);
        checkOutput("rstMissCnt", 64'(miss_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < LINES; i++) begin
            mValid[i] = 0;
            mDirty[i] = 0;
        end
        expHits   = 0;
        expMisses = 0;
        gold.delete();
        foreach (backMem[k]) gold[k] = backMem[k];

        mem_resp_valid = 1'b1;
        mem_resp_data  = {WORDS{32'hFEED_F00D}};
        @(negedge clk);
        mem_resp_valid = 1'b0;
        @(negedge clk);
        checkOutput("orphanValid", 64'(is_output_valid), 64'd0);
        checkOutput("orphanReq", 64'(mem_req_valid), 64'd0);
        checkOutput("orphanReady", 64'(is_ready), 64'd1);
        checkOutput("orphanMiss", 64'(miss_count), 64'd0);
    endtask

    initial begin
        logic [TAG_WIDTH-1:0] tagSet [4];
        logic [31:0]          ra;
        tagSet = '{24'h000001, 24'h000002, 24'h000009, 24'h000033};

        reset          = 1'b1;
        is_input_valid = 1'b0;
        addr           = 32'd0;
        mem_rw         = 1'b0;
        din            = 32'd0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        expHits        = 0;
        expMisses      = 0;
        for (int i = 0; i < LINES; i++) begin
            mValid[i] = 0;
            mDirty[i] = 0;
            mTag[i]   = '0;
        end

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetReady", 64'(is_ready), 64'd0);
        checkOutput("resetOutValid", 64'(is_output_valid), 64'd0);
        checkOutput("resetDout", 64'(dout), 64'd0);
        checkOutput("resetHit", 64'(is_hit), 64'd0);
        checkOutput("resetReqValid", 64'(mem_req_valid), 64'd0);
        checkOutput("resetHitCnt", 64'(hit_count), 64'd0);
        checkOutput("resetMissCnt", 64'(miss_count), 64'd0);
        reset = 1'b1;

        $display("[TB] directed sequence");
        applyStimulus(1'b0, 32'h0000_0100, 32'd0, -1);
        applyStimulus(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, -1);
        applyStimulus(1'b0, 32'h0000_0104, 32'd0, -1);
        applyStimulus(1'b0, 32'h0000_0904, 32'd0, -1);
        applyStimulus(1'b0, 32'h0000_2210, 32'd0, 5);
        strayResp();
        applyStimulus(1'b0, 32'h0000_0904, 32'd0, -1);

        $display("[TB] random sequence");
        for (int n = 0; n < 150; n++) begin
            ra = {tagSet[$urandom_range(0, 3)], 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            applyStimulus(1'($urandom_range(0, 1)), ra, $urandom, -1);
            if ($urandom_range(0, 9) == 0) strayResp();
        end

        $display("[TB] reset during fill");
        resetDuringFill();
        applyStimulus(1'b0, 32'h0000_0100, 32'd0, -1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
